// File: rtl/lpcu_pkg.sv
// Shared definitions for the low-power control unit issue path: opcodes,
// issue FSM states and control-flow classification.
package lpcu_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_AND    = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_OR     = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_XOR    = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_JUMP   = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_SLL    = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_SRL    = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HAZARD
  } issue_state_t;

  function automatic logic is_ctrl_flow(input logic [OPCODE_W-1:0] op);
    return (op == OP_BRANCH) || (op == OP_JUMP);
  endfunction

  // Opcodes 1100-1111 are unassigned.
  function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
    return op[OPCODE_W-1 -: 2] == 2'b11;
  endfunction

endpackage

// File: rtl/lpcu_issue_fifo.sv
// Small synchronous FIFO buffering opcodes between fetch and issue.
// Wrap-around pointers plus an explicit occupancy count.
module lpcu_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop  && !flush && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lpcu_opcode_issuer.sv
// Issue stage: buffers fetched words and presents one opcode per cycle to the
// control unit, inserting bubbles after BRANCH/JUMP. Define LPCU_ILLEGAL_FILTER_EN
// to drop opcodes 1100-1111 at the FIFO input instead of issuing them.
module lpcu_opcode_issuer
  import lpcu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned BUBBLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     stall,
  input  logic                     flush,
  output logic [3:0]               opcode,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     illegal_seen
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(BUBBLES + 1);

  issue_state_t        state;
  logic [CNT_W-1:0]    bub_cnt;
  logic [OPCODE_W-1:0] in_op;
  logic [OPCODE_W-1:0] head_op;
  logic                accept;
  logic                store;
  logic                pop;
  logic                unused_operand_bits;

  assign in_op               = in_instr[INSTR_W-1 -: OPCODE_W];
  assign unused_operand_bits = ^in_instr[INSTR_W-OPCODE_W-1:0];
  assign in_ready            = (fifo_count != CW'(DEPTH));
  assign accept              = in_valid && in_ready;

`ifdef LPCU_ILLEGAL_FILTER_EN
  assign store = accept && !is_illegal(in_op);
`else
  assign store = accept;
`endif

  assign pop = (state == S_ISSUE) && !stall && !flush && (fifo_count != '0);

  lpcu_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (OPCODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (store),
    .pop   (pop),
    .flush (flush),
    .wdata (in_op),
    .rdata (head_op),
    .count (fifo_count)
  );

  // Issue FSM; opcode only updates on a pop so the decoder input stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bub_cnt      <= '0;
      valid        <= 1'b0;
      opcode       <= '0;
      illegal_seen <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept && is_illegal(in_op)) illegal_seen <= 1'b1;

      if (flush) begin
        state   <= S_IDLE;
        bub_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (store) state <= S_ISSUE;
          end
          S_ISSUE: begin
            if (pop) begin
              valid  <= 1'b1;
              opcode <= head_op;
              if (is_ctrl_flow(head_op)) begin
                state   <= S_HAZARD;
                bub_cnt <= CNT_W'(BUBBLES);
              end else if (fifo_count == CW'(1) && !store) begin
                state <= S_IDLE;
              end
            end else if (fifo_count == '0 && !store) begin
              state <= S_IDLE;
            end
          end
          S_HAZARD: begin
            // Countdown ignores stall so the bubble window is fixed.
            bub_cnt <= bub_cnt - CNT_W'(1);
            if (bub_cnt == CNT_W'(1)) begin
              state <= (fifo_count != '0 || store) ? S_ISSUE : S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpcu_opcode_issuer.sv
// Bench for lpcu_opcode_issuer: cycle vector table plus directed sequences,
// with an opcode scoreboard checking every issued instruction in order.
module tb_lpcu_opcode_issuer;
  import lpcu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  opcode;
  logic        valid;
  logic [2:0]  fifo_count;
  logic        illegal_seen;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb [$];
  logic [3:0] last_op = '0;
  logic       rst_q = 1'b1;

  typedef struct {
    logic        in_v;
    logic [15:0] instr;
    logic        st;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt [19];

  lpcu_opcode_issuer #(
    .DEPTH   (4),
    .INSTR_W (16),
    .BUBBLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .stall        (stall),
    .flush        (flush),
    .opcode       (opcode),
    .valid        (valid),
    .fifo_count   (fifo_count),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic st,
                       input logic fl, input logic exp_acc);
    in_valid = v;
    in_instr = ins;
    stall    = st;
    flush    = fl;
    if (v && exp_acc && !fl && !rst) begin
`ifdef LPCU_ILLEGAL_FILTER_EN
      if (ins[15:14] != 2'b11) sb.push_back(ins[15:12]);
`else
      sb.push_back(ins[15:12]);
`endif
    end
  endtask

  // Flush and reset discard everything still pending in the model.
  always @(posedge clk) begin
    rst_q <= rst;
    if (rst || flush) sb.delete();
  end

  // Scoreboard and opcode-freeze monitor.
  always @(negedge clk) begin
    if (!rst_q) begin
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", {28'd0, opcode}, 32'hFFFF_FFFF);
        end else begin
          check("issue_order", {28'd0, opcode}, {28'd0, sb.pop_front()});
        end
      end else begin
        check("opcode_frozen", {28'd0, opcode}, {28'd0, last_op});
      end
    end
    last_op = opcode;
  end

  initial begin
    vt[0]  = '{1'b1, {OP_ADD,    12'hA5C}, 1'b0, 1'b0, 4'h0, 3'd1};
    vt[1]  = '{1'b1, {OP_SUB,    12'h3C1}, 1'b0, 1'b1, 4'h1, 3'd1};
    vt[2]  = '{1'b1, {OP_XOR,    12'hFFF}, 1'b0, 1'b1, 4'h2, 3'd1};
    vt[3]  = '{1'b0, 16'h0000,             1'b0, 1'b1, 4'h5, 3'd0};
    vt[4]  = '{1'b0, 16'h0000,             1'b0, 1'b0, 4'h5, 3'd0};
    vt[5]  = '{1'b1, {OP_BRANCH, 12'h012}, 1'b0, 1'b0, 4'h5, 3'd1};
    vt[6]  = '{1'b1, {OP_ADD,    12'h777}, 1'b0, 1'b1, 4'h8, 3'd1};
    vt[7]  = '{1'b0, 16'h0000,             1'b0, 1'b0, 4'h8, 3'd1};
    vt[8]  = '{1'b0, 16'h0000,             1'b0, 1'b0, 4'h8, 3'd1};
    vt[9]  = '{1'b0, 16'h0000,             1'b0, 1'b1, 4'h1, 3'd0};
    vt[10] = '{1'b0, 16'h0000,             1'b0, 1'b0, 4'h1, 3'd0};
    vt[11] = '{1'b1, {OP_JUMP,   12'h800}, 1'b1, 1'b0, 4'h1, 3'd1};
    vt[12] = '{1'b0, 16'h0000,             1'b1, 1'b0, 4'h1, 3'd1};
    vt[13] = '{1'b1, {OP_OR,     12'h155}, 1'b0, 1'b1, 4'h9, 3'd1};
    vt[14] = '{1'b0, 16'h0000,             1'b1, 1'b0, 4'h9, 3'd1};
    vt[15] = '{1'b0, 16'h0000,             1'b1, 1'b0, 4'h9, 3'd1};
    vt[16] = '{1'b0, 16'h0000,             1'b1, 1'b0, 4'h9, 3'd1};
    vt[17] = '{1'b0, 16'h0000,             1'b0, 1'b1, 4'h4, 3'd0};
    vt[18] = '{1'b0, 16'h0000,             1'b0, 1'b0, 4'h4, 3'd0};

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    check("rst_valid",   {31'd0, valid},        32'd0);
    check("rst_opcode",  {28'd0, opcode},       32'd0);
    check("rst_ready",   {31'd0, in_ready},     32'd1);
    check("rst_count",   {29'd0, fifo_count},   32'd0);
    check("rst_illegal", {31'd0, illegal_seen}, 32'd0);

    // Back-to-back issue, BRANCH/JUMP bubbles, stall interaction.
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].in_v, vt[i].instr, vt[i].st, 1'b0, 1'b1);
      step();
      check($sformatf("vec%0d_valid", i), {31'd0, valid},      {31'd0, vt[i].e_valid});
      check($sformatf("vec%0d_opcode", i), {28'd0, opcode},    {28'd0, vt[i].e_op});
      check($sformatf("vec%0d_count", i), {29'd0, fifo_count}, {29'd0, vt[i].e_cnt});
      check($sformatf("vec%0d_ready", i), {31'd0, in_ready},   32'd1);
    end

    // Fill under stall until full; a fifth word is refused.
    drive(1'b1, {OP_AND,   12'h111}, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, {OP_LOAD,  12'h222}, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, {OP_STORE, 12'h333}, 1'b1, 1'b0, 1'b1); step();
    check("fill3_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, {OP_SLL,   12'h444}, 1'b1, 1'b0, 1'b1); step();
    check("full_count", {29'd0, fifo_count}, 32'd4);
    check("full_ready", {31'd0, in_ready},   32'd0);
    drive(1'b1, {OP_SRL,   12'h555}, 1'b1, 1'b0, 1'b0); step();
    check("full_refuse_count", {29'd0, fifo_count}, 32'd4);
    check("full_refuse_valid", {31'd0, valid},      32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    check("drain_first_ready", {31'd0, in_ready},   32'd1);
    check("drain_first_count", {29'd0, fifo_count}, 32'd3);
    begin
      int budget = 0;
      while (sb.size() != 0 && budget < 20) begin
        step();
        budget++;
      end
      check("drain_timeout", {31'd0, (budget >= 20)}, 32'd0);
    end
    step();
    check("drain_count", {29'd0, fifo_count}, 32'd0);
    check("drain_ready", {31'd0, in_ready},   32'd1);

    // Flush with a concurrent push discards everything.
    drive(1'b1, {OP_ADD, 12'h001}, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, {OP_SUB, 12'h002}, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, {OP_AND, 12'h003}, 1'b1, 1'b0, 1'b1); step();
    check("preflush_count", {29'd0, fifo_count}, 32'd3);
    drive(1'b1, {OP_XOR, 12'h004}, 1'b0, 1'b1, 1'b1); step();
    check("flush_count", {29'd0, fifo_count}, 32'd0);
    check("flush_valid", {31'd0, valid},      32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    check("postflush_count", {29'd0, fifo_count}, 32'd0);
    check("pre_illegal", {31'd0, illegal_seen}, 32'd0);

    // Illegal opcode 1101: dropped with filter, issued without.
    drive(1'b1, 16'hD123, 1'b0, 1'b0, 1'b1);
    check("illegal_handshake", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("illegal_seen_set", {31'd0, illegal_seen}, 32'd1);
`ifdef LPCU_ILLEGAL_FILTER_EN
    check("illegal_dropped", {29'd0, fifo_count}, 32'd0);
`else
    check("illegal_stored", {29'd0, fifo_count}, 32'd1);
    step();
    check("illegal_issue_valid",  {31'd0, valid},  32'd1);
    check("illegal_issue_opcode", {28'd0, opcode}, 32'hD);
`endif
    repeat (4) step();
    check("illegal_sb_empty", sb.size(), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); step();
    check("illegal_sticky_flush", {31'd0, illegal_seen}, 32'd1);

    // Reset during a bubble countdown, then LOAD issues without bubbles.
    drive(1'b1, {OP_BRANCH, 12'h0F0}, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); step();
    check("hz_branch_valid",  {31'd0, valid},  32'd1);
    check("hz_branch_opcode", {28'd0, opcode}, 32'h8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hzrst_valid",   {31'd0, valid},        32'd0);
    check("hzrst_opcode",  {28'd0, opcode},       32'd0);
    check("hzrst_ready",   {31'd0, in_ready},     32'd1);
    check("hzrst_count",   {29'd0, fifo_count},   32'd0);
    check("hzrst_illegal", {31'd0, illegal_seen}, 32'd0);
    drive(1'b1, {OP_LOAD, 12'hABC}, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); step();
    check("load_valid",  {31'd0, valid},  32'd1);
    check("load_opcode", {28'd0, opcode}, 32'h6);
    repeat (3) step();
    check("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
